// File: rtl/alu_muldiv_seq_if.sv
// Bundle between the multiply/divide sequencer, the microcode control that starts it,
// and the shared 16-bit ALU datapath. Bit 0 is the MSB on every bus.
interface alu_muldiv_seq_if;
  // Operation request from microcode
  logic        start;
  logic        op;
  logic [0:15] x;
  logic [0:15] y;
  logic [0:15] z;

  // ALU operand buses and function select
  logic [0:15] alu_a;
  logic [0:15] alu_ac;
  logic        saryt;
  logic        sd_;
  logic        sb_;
  logic        sca_;
  logic        saa_;
  logic        scb_;
  logic        sab_;
  logic        p16_;

  // ALU results
  logic [0:15] alu_f;
  logic        alu_carry_;

  // Status and result
  logic        busy;
  logic        done;
  logic        ovf;
  logic [0:15] hi;
  logic [0:15] lo;

  modport slave (
    input  start, op, x, y, z, alu_f, alu_carry_,
    output alu_a, alu_ac, saryt, sd_, sb_, sca_, saa_, scb_, sab_, p16_,
    output busy, done, ovf, hi, lo
  );

  modport master (
    output start, op, x, y, z, alu_f, alu_carry_,
    input  alu_a, alu_ac, saryt, sd_, sb_, sca_, saa_, scb_, sab_, p16_,
    input  busy, done, ovf, hi, lo
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned 16x16 multiply and 32/16 divide, one shift-add or shift-subtract
// step per clock, borrowing the shared 74181-based ALU for every arithmetic step.
module alu_muldiv_seq (
  input  logic            clk_sys,
  input  logic            rst,
  alu_muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DCHK = 2'd2,
    S_DIV  = 2'd3
  } state_t;

  // ALU function codes packed as {saryt, sd_, sca_, sb_, saa_, p16_}
  typedef logic [5:0] alu_code_t;
  localparam alu_code_t C_PASS = 6'b000001;
  localparam alu_code_t C_ADD  = 6'b101101;
  localparam alu_code_t C_SUB  = 6'b110010;

  state_t      r_state;
  logic [0:15] r_x;
  logic [0:15] r_hi;
  logic [0:15] r_lo;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_ovf;

  state_t      w_state_nxt;
  logic [0:15] w_x_nxt;
  logic [0:15] w_hi_nxt;
  logic [0:15] w_lo_nxt;
  logic [3:0]  w_cnt_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_ovf_nxt;
  alu_code_t   w_code;
  logic [0:15] w_alu_a;
  logic        w_add_carry;
  logic        w_last;

  assign w_last = (r_cnt == 4'd15);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_ovf_nxt   = r_ovf;
    w_done_nxt  = 1'b0;
    w_code      = C_PASS;
    w_alu_a     = r_hi;
    w_add_carry = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_x_nxt     = bus.x;
          w_hi_nxt    = bus.op ? bus.z : 16'h0000;
          w_lo_nxt    = bus.y;
          w_cnt_nxt   = 4'd0;
          w_ovf_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = bus.op ? S_DCHK : S_MUL;
        end
      end

      S_MUL: begin
        // The ADD carry is product bit 17; it shifts into hi[0] with the sum.
        w_code      = r_lo[15] ? C_ADD : C_PASS;
        w_add_carry = r_lo[15] & ~bus.alu_carry_;
        w_hi_nxt    = {w_add_carry, bus.alu_f[0:14]};
        w_lo_nxt    = {bus.alu_f[15], r_lo[0:14]};
        w_cnt_nxt   = r_cnt + 4'd1;
        if (w_last) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      S_DCHK: begin
        // High word not below divisor: quotient would not fit (covers x = 0).
        w_code = C_SUB;
        if (!bus.alu_carry_) begin
          w_ovf_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DIV;
        end
      end

      S_DIV: begin
        // With r_hi[0] set the 17-bit remainder already exceeds x, so subtract
        // unconditionally; the 16-bit difference is then exact.
        w_code  = C_SUB;
        w_alu_a = {r_hi[1:15], r_lo[0]};
        if (r_hi[0] || !bus.alu_carry_) begin
          w_hi_nxt = bus.alu_f;
          w_lo_nxt = {r_lo[1:15], 1'b1};
        end else begin
          w_hi_nxt = {r_hi[1:15], r_lo[0]};
          w_lo_nxt = {r_lo[1:15], 1'b0};
        end
        w_cnt_nxt = r_cnt + 4'd1;
        if (w_last) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register updates from
  // the same pre-edge values, independent of statement order.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign bus.alu_a  = w_alu_a;
  assign bus.alu_ac = r_x;
  assign bus.saryt  = w_code[5];
  assign bus.sd_    = w_code[4];
  assign bus.sca_   = w_code[3];
  assign bus.sb_    = w_code[2];
  assign bus.saa_   = w_code[1];
  assign bus.p16_   = w_code[0];
  assign bus.scb_   = w_code[3];
  assign bus.sab_   = w_code[1];

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.ovf  = r_ovf;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
